// File: rtl/cga_alu_qseq_if.sv
// Bus between the CGA ALU control logic and the Q-register step sequencer.
// The master issues START/OP and returns Q register and ALU sign feedback.
// The slave (the sequencer) drives the Q register mode and the ALU step enables.
interface cga_alu_qseq_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH + 1);

  logic             START;
  logic [1:0]       OP_1_0;
  logic [WIDTH-1:0] Q_15_0;
  logic             F_15;
  logic [1:0]       QSEL_1_0;
  logic             QLI;
  logic             ALU_ADD;
  logic             ALU_SUB;
  logic             BUSY;
  logic             DONE;
  logic [SW-1:0]    STEP_4_0;
  logic             QZERO;

  modport master (
    output START, OP_1_0, Q_15_0, F_15,
    input  QSEL_1_0, QLI, ALU_ADD, ALU_SUB, BUSY, DONE, STEP_4_0, QZERO
  );

  modport slave (
    input  START, OP_1_0, Q_15_0, F_15,
    output QSEL_1_0, QLI, ALU_ADD, ALU_SUB, BUSY, DONE, STEP_4_0, QZERO
  );
endinterface

// File: rtl/cga_alu_qseq.sv
// Q-register step sequencer for the CGA ALU: runs WIDTH-step multiply and
// non-restoring divide, and normalize (left shift until the two top bits differ).
module cga_alu_qseq #(
  parameter int WIDTH = 16
) (
  input  logic           ALUCLK,
  input  logic           RESET,
  cga_alu_qseq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_MUL = 2'b01, OP_DIV = 2'b10, OP_NORM = 2'b11} op_t;
  typedef enum logic [1:0] {Q_HOLD = 2'b00, Q_LOAD = 2'b01, Q_SHL = 2'b10, Q_ROR = 2'b11} qsel_t;

  state_t        state, state_nxt;
  op_t           op;
  logic          qbit_prev;
  logic [SW-1:0] step;
  logic          qzero;
  qsel_t         qsel;
  logic          qli, alu_add, alu_sub;
  logic          start_ok;
  logic          norm_exit;

  assign start_ok  = bus.START && (bus.OP_1_0 != OP_NONE);
  // Normalized once the two top bits differ; an all-equal word stops after WIDTH-1 shifts.
  assign norm_exit = (bus.Q_15_0[WIDTH-1] ^ bus.Q_15_0[WIDTH-2]) || (step == STEP_LAST);

  // Next-state and step-control decode.
  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    qsel      = Q_HOLD;
    qli       = 1'b0;
    alu_add   = 1'b0;
    alu_sub   = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_LOAD;
      S_LOAD: begin
        qsel      = Q_LOAD;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        case (op)
          OP_MUL: begin
            qsel    = Q_ROR;
            alu_add = bus.Q_15_0[0];
            if (step == STEP_LAST) state_nxt = S_DONE;
          end
          OP_DIV: begin
            // Non-restoring: subtract after a 1 quotient bit, add back after a 0.
            qsel    = Q_SHL;
            alu_sub = qbit_prev;
            alu_add = ~qbit_prev;
            qli     = ~bus.F_15;
            if (step == STEP_LAST) state_nxt = S_FIX;
          end
          OP_NORM: begin
            // The exit test looks at the Q word of this cycle, so the shift select is decided here too.
            if (norm_exit) state_nxt = S_DONE;
            else           qsel      = Q_SHL;
          end
          default: state_nxt = S_DONE;
        endcase
      end
      S_FIX: begin
        // Restore the remainder if the last trial step left it negative.
        alu_add   = ~qbit_prev;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, latched operation, quotient bit, step counter and normalize-zero flag.
  // NOTE: registered state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      op        <= OP_NONE;
      qbit_prev <= 1'b0;
      step      <= '0;
      qzero     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            op   <= op_t'(bus.OP_1_0);
            step <= '0;
          end
        end
        S_LOAD: if (op == OP_DIV) qbit_prev <= 1'b1;
        S_RUN: begin
          if (op == OP_DIV) qbit_prev <= ~bus.F_15;
          if (op == OP_NORM && step == '0) qzero <= (bus.Q_15_0 == '0);
          // NORM counts shifts only, so its exit cycle does not advance the count.
          if (!(op == OP_NORM && norm_exit) && step != STEP_MAX) step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.QSEL_1_0 = qsel;
  assign bus.QLI      = qli;
  assign bus.ALU_ADD  = alu_add;
  assign bus.ALU_SUB  = alu_sub;
  assign bus.BUSY     = (state != S_IDLE);
  assign bus.DONE     = (state == S_DONE);
  assign bus.STEP_4_0 = step;
  assign bus.QZERO    = qzero;
endmodule

// File: tb/tb_cga_alu_qseq.sv
// Self-checking bench for cga_alu_qseq: directed vector table, multi-cycle
// corner sequences (reset mid-run, OP=00, START while busy) and random operations
// compared cycle by cycle against an operation-level reference model.
module tb_cga_alu_qseq;
  localparam logic [1:0] MUL = 2'b01, DIV = 2'b10, NORM = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] q_reg = '0;
  logic [15:0] f_val = '0;
  int checks = 0;
  int errors = 0;
  logic model_qz;

  cga_alu_qseq_if bus ();
  cga_alu_qseq dut (.ALUCLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  // Q register environment: follows the sequencer's select, loads the ALU result f_val.
  always @(posedge clk) begin
    case (bus.QSEL_1_0)
      2'b01:   q_reg <= f_val;
      2'b10:   q_reg <= {q_reg[14:0], bus.QLI};
      2'b11:   q_reg <= {q_reg[0], q_reg[15:1]};
      default: ;
    endcase
  end
  assign bus.Q_15_0 = q_reg;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] fv;
    logic [15:0] fseq;
    bit          poke;
    int          lat;
    int          step;
    logic        qz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Number of left shifts normalize needs for word v.
  function automatic int norm_shifts(input logic [15:0] v);
    logic [15:0] w;
    int n;
    w = v;
    n = 0;
    while (n < 15 && w[15] == w[14]) begin
      w = w << 1;
      n++;
    end
    return n;
  endfunction

  // Cycle (counted from the START cycle = 0) on which DONE is expected.
  function automatic int exp_lat(input logic [1:0] op, input logic [15:0] fv);
    if (op == MUL) return 18;
    if (op == DIV) return 19;
    return 3 + norm_shifts(fv);
  endfunction

  function automatic int exp_step(input logic [1:0] op, input logic [15:0] fv);
    return (op == NORM) ? norm_shifts(fv) : 16;
  endfunction

  // Expected {QSEL, QLI, ALU_ADD, ALU_SUB, BUSY, DONE} on cycle c of an operation.
  function automatic logic [6:0] exp_cycle(input logic [1:0] op, input logic [15:0] fv,
                                           input logic [15:0] fs, input int c);
    int   lat;
    int   k;
    logic qp;
    lat = exp_lat(op, fv);
    k   = c - 2;
    if (c < 1 || c > lat) return 7'b00_000_00;
    if (c == lat) return 7'b00_000_11;
    if (c == 1)   return 7'b01_000_10;
    if (op == MUL) return {2'b11, 1'b0, fv[k], 1'b0, 2'b10};
    if (op == DIV) begin
      if (c == lat - 1) return {2'b00, 1'b0, fs[15], 1'b0, 2'b10};
      qp = (k == 0) ? 1'b1 : ~fs[k-1];
      return {2'b10, ~fs[k], ~qp, qp, 2'b10};
    end
    if (c == lat - 1) return 7'b00_000_10;
    return 7'b10_000_10;
  endfunction

  // Runs one operation, checking every cycle; returns observed latency, STEP and QZERO.
  task automatic run_op(input logic [1:0] op, input logic [15:0] fv, input logic [15:0] fs,
                        input bit poke, output int lat, output logic [4:0] step, output logic qz);
    int   elat;
    logic [6:0] obs;
    elat  = exp_lat(op, fv);
    f_val = fv;
    lat   = 0;
    step  = '0;
    qz    = 1'b0;
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP_1_0 = op; bus.F_15 = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 25; c++) begin
      bus.START  = poke && (c == 5 || c == elat);
      bus.OP_1_0 = MUL;
      bus.F_15   = (op == DIV && c >= 2 && c <= 17) ? fs[c-2] : 1'b0;
      @(negedge clk);
      obs = {bus.QSEL_1_0, bus.QLI, bus.ALU_ADD, bus.ALU_SUB, bus.BUSY, bus.DONE};
      check($sformatf("cycle op=%0d fv=%h c=%0d", op, fv, c), 32'(obs), 32'(exp_cycle(op, fv, fs, c)));
      check($sformatf("add_sub_excl op=%0d c=%0d", op, c), 32'(bus.ALU_ADD & bus.ALU_SUB), 32'd0);
      if (bus.DONE) begin
        lat  = c;
        step = bus.STEP_4_0;
        qz   = bus.QZERO;
        break;
      end
      @(posedge clk); #1;
    end
    bus.START = 1'b0;
    bus.F_15  = 1'b0;
    if (lat == 0) check($sformatf("done_timeout op=%0d", op), 32'd0, 32'd1);
    // One cycle later: back in IDLE (any START seen during DONE ignored), STEP held.
    @(negedge clk);
    check($sformatf("post_done_idle op=%0d", op), {29'd0, bus.BUSY, bus.QSEL_1_0}, 32'd0);
    check($sformatf("step_held op=%0d", op), 32'(bus.STEP_4_0), 32'(step));
  endtask

  vec_t vecs[9];
  int   lat;
  logic [4:0] step;
  logic qz;

  initial begin
    vecs[0] = '{NORM, 16'h0100, 16'h0000, 1'b0,  9,  6, 1'b0};
    vecs[1] = '{NORM, 16'h0000, 16'h0000, 1'b1, 18, 15, 1'b1};
    vecs[2] = '{MUL,  16'h1234, 16'h0000, 1'b1, 18, 16, 1'b1};
    vecs[3] = '{DIV,  16'h00FF, 16'hAAAA, 1'b0, 19, 16, 1'b1};
    vecs[4] = '{NORM, 16'h4000, 16'h0000, 1'b0,  3,  0, 1'b0};
    vecs[5] = '{NORM, 16'hFFFF, 16'h0000, 1'b0, 18, 15, 1'b0};
    vecs[6] = '{NORM, 16'hC000, 16'h0000, 1'b1,  4,  1, 1'b0};
    vecs[7] = '{MUL,  16'h8001, 16'h0000, 1'b0, 18, 16, 1'b0};
    vecs[8] = '{DIV,  16'h7FFF, 16'h0000, 1'b1, 19, 16, 1'b0};

    rst = 1'b1;
    bus.START = 1'b0; bus.OP_1_0 = 2'b00; bus.F_15 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.QSEL_1_0, bus.QLI, bus.ALU_ADD, bus.ALU_SUB, bus.BUSY, bus.DONE, bus.STEP_4_0, bus.QZERO}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_qz = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].fv, vecs[i].fseq, vecs[i].poke, lat, step, qz);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d step", i), 32'(step), 32'(vecs[i].step));
      check($sformatf("vec%0d qzero", i), 32'(qz), 32'(vecs[i].qz));
      model_qz = vecs[i].qz;
    end

    // START with OP=00 is ignored.
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP_1_0 = 2'b00;
    @(posedge clk); #1;
    bus.START = 1'b0;
    @(negedge clk);
    check("op00_ignored", {29'd0, bus.BUSY, bus.QSEL_1_0}, 32'd0);
    check("op00_step_kept", 32'(bus.STEP_4_0), 32'd16);

    // RESET during MUL RUN step 7 returns to IDLE with everything cleared.
    f_val = 16'h5A5A;
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP_1_0 = MUL;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_run_step7", {27'd0, bus.QSEL_1_0, bus.STEP_4_0}, {27'd0, 2'b11, 5'd7});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_run",
          {bus.QSEL_1_0, bus.QLI, bus.ALU_ADD, bus.ALU_SUB, bus.BUSY, bus.DONE, bus.STEP_4_0, bus.QZERO}, 32'd0);
    model_qz = 1'b0;

    // Random operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  rop;
      logic [15:0] rfv, rfs;
      logic        eqz;
      rop = 2'($urandom_range(1, 3));
      rfv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'($urandom) >> $urandom_range(0, 16));
      rfs = 16'($urandom);
      run_op(rop, rfv, rfs, bit'($urandom_range(0, 1)), lat, step, qz);
      eqz = (rop == NORM) ? (rfv == 16'h0000) : model_qz;
      check($sformatf("rand%0d latency", n), 32'(lat), 32'(exp_lat(rop, rfv)));
      check($sformatf("rand%0d step", n), 32'(step), 32'(exp_step(rop, rfv)));
      check($sformatf("rand%0d qzero", n), 32'(qz), 32'(eqz));
      model_qz = eqz;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
